// File: rtl/gr_heep_obi_demux_pkg.sv
// gr_heep_obi_demux_pkg: shared constants and flattened OBI / address-map types
// for the GR-HEEP OBI demultiplexer and its address decoder.
package gr_heep_obi_demux_pkg;

    // Data returned by the internal error target on unmatched accesses.
    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

    // Conventional demux port assignment in GR-HEEP.
    localparam int unsigned INT_SLAVE_IDX = 32'd0;
    localparam int unsigned EXT_SLAVE_IDX = 32'd1;

    // OBI request: {req, we, be, addr, wdata}
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    // OBI response: {gnt, rvalid, rdata}
    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    // Address-map rule: matches start_addr <= addr < end_addr.
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    localparam int unsigned OBI_REQ_W  = $bits(obi_req_t);
    localparam int unsigned OBI_RESP_W = $bits(obi_resp_t);
    localparam int unsigned RULE_W     = $bits(addr_map_rule_t);

    // Index width able to address num_idx targets (never narrower than 1 bit).
    function automatic int unsigned idx_width(input int unsigned num_idx);
        if (num_idx > 32'd1) begin
            return unsigned'($clog2(num_idx));
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/gr_heep_addr_decode.sv
// gr_heep_addr_decode: combinational address-map matcher. Lowest-numbered
// matching rule wins; rules pointing at an index >= NSLAVE are ignored.
// Reusable by the external crossbar.
module gr_heep_addr_decode
    import gr_heep_obi_demux_pkg::*;
#(
    parameter int unsigned NUM_RULES = 1,
    parameter int unsigned NSLAVE    = 2,
    parameter int unsigned IdxW      = 1
) (
    input  logic [31:0]                 addr_i,
    input  logic [NUM_RULES*RULE_W-1:0] addr_map_i,
    output logic [IdxW-1:0]             idx_o,
    output logic                        match_o
);

    addr_map_rule_t rules_s [NUM_RULES];
    logic           take_s  [NUM_RULES];

    for (genvar g = 0; g < NUM_RULES; g++) begin : gen_rule
        assign rules_s[g] = addr_map_rule_t'(addr_map_i[g*RULE_W +: RULE_W]);
        assign take_s[g]  = (addr_i >= rules_s[g].start_addr) &&
                            (addr_i <  rules_s[g].end_addr)   &&
                            (rules_s[g].idx < NSLAVE);
    end

    // Priority scan: the first (lowest) matching rule claims the address.
    always_comb begin
        idx_o   = '0;
        match_o = 1'b0;
        for (int unsigned r = 0; r < NUM_RULES; r++) begin
            idx_o   = (!match_o && take_s[r]) ? rules_s[r].idx[IdxW-1:0] : idx_o;
            match_o = match_o | take_s[r];
        end
    end

endmodule

// File: rtl/gr_heep_obi_demux.sv
// gr_heep_obi_demux: 1-to-NSLAVE OBI demultiplexer with in-order responses and
// outstanding-transaction tracking. Requests are routed combinationally (no
// added latency); a request to a different target waits until every response
// from the current target has returned, so responses can never reorder.
// Optional macro GR_HEEP_OBI_DEMUX_ERR_RESP_EN: unmatched addresses go to an
// internal error target (index NSLAVE) that answers with ERR_RDATA.
module gr_heep_obi_demux
    import gr_heep_obi_demux_pkg::*;
#(
    parameter  int unsigned NSLAVE          = 2,
    parameter  int unsigned NUM_RULES       = 1,
    parameter  int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned IdxW            = idx_width(NSLAVE),
    localparam int unsigned CntW            = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_RULES*RULE_W-1:0]   addr_map_i,
    input  logic [IdxW-1:0]               default_idx_i,
    input  logic [OBI_REQ_W-1:0]          master_req_i,
    output logic [OBI_RESP_W-1:0]         master_resp_o,
    output logic [NSLAVE*OBI_REQ_W-1:0]   slave_req_o,
    input  logic [NSLAVE*OBI_RESP_W-1:0]  slave_resp_i,
    output logic [CntW-1:0]               outstanding_o,
    output logic                          busy_o
);

`ifdef GR_HEEP_OBI_DEMUX_ERR_RESP_EN
    localparam int unsigned NTGT = NSLAVE + 32'd1;
`else
    localparam int unsigned NTGT = NSLAVE;
`endif
    localparam int unsigned     TgtW    = idx_width(NTGT);
    localparam logic [CntW-1:0] CNT_MAX = CntW'(MAX_OUTSTANDING);
    localparam logic [CntW-1:0] CNT_ONE = CntW'(1);
`ifdef GR_HEEP_OBI_DEMUX_ERR_RESP_EN
    localparam logic [TgtW-1:0] ERR_IDX = TgtW'(NSLAVE);
`endif

    obi_req_t        m_req_s;
    obi_resp_t       m_resp_s;
    obi_req_t        s_req_s  [NSLAVE];
    obi_resp_t       s_resp_s [NSLAVE];

    logic [IdxW-1:0] dec_idx_s;
    logic            dec_match_s;
    logic [TgtW-1:0] sel_s;
    logic            allow_s;
    logic            sel_gnt_s;
    logic            gnt_s;
    logic            rvalid_s;
    logic [31:0]     rdata_s;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [TgtW-1:0] tgt_q, tgt_d;
    logic            busy_q, busy_d;
`ifdef GR_HEEP_OBI_DEMUX_ERR_RESP_EN
    logic            err_rvalid_q, err_rvalid_d;
`endif

    assign m_req_s = obi_req_t'(master_req_i);

    for (genvar g = 0; g < NSLAVE; g++) begin : gen_port
        assign s_resp_s[g] = obi_resp_t'(slave_resp_i[g*OBI_RESP_W +: OBI_RESP_W]);
        assign slave_req_o[g*OBI_REQ_W +: OBI_REQ_W] = s_req_s[g];
    end

    gr_heep_addr_decode #(
        .NUM_RULES (NUM_RULES),
        .NSLAVE    (NSLAVE),
        .IdxW      (IdxW)
    ) u_addr_decode (
        .addr_i     (m_req_s.addr),
        .addr_map_i (addr_map_i),
        .idx_o      (dec_idx_s),
        .match_o    (dec_match_s)
    );

    // Target selection: decoded rule, otherwise the fallback target.
    always_comb begin
        if (dec_match_s) begin
            sel_s = TgtW'(dec_idx_s);
        end else begin
`ifdef GR_HEEP_OBI_DEMUX_ERR_RESP_EN
            sel_s = ERR_IDX;
`else
            sel_s = TgtW'(default_idx_i);
`endif
        end
    end

    // Issue allowance: idle, or same target with room left in the window.
    always_comb begin
        if (cnt_q == '0) begin
            allow_s = 1'b1;
        end else if ((sel_s == tgt_q) && (cnt_q < CNT_MAX)) begin
            allow_s = 1'b1;
        end else begin
            allow_s = 1'b0;
        end
    end

    // Request fan-out: payload broadcast to every port, req only to the selected one.
    always_comb begin
        s_req_s   = '{default: '0};
        sel_gnt_s = 1'b0;
        for (int unsigned i = 0; i < NSLAVE; i++) begin
            s_req_s[i]     = m_req_s;
            s_req_s[i].req = m_req_s.req & allow_s & (sel_s == TgtW'(i));
            sel_gnt_s      = sel_gnt_s | (s_resp_s[i].gnt & (sel_s == TgtW'(i)));
        end
`ifdef GR_HEEP_OBI_DEMUX_ERR_RESP_EN
        sel_gnt_s = sel_gnt_s | (sel_s == ERR_IDX);
`endif
    end

    assign gnt_s = m_req_s.req & allow_s & sel_gnt_s;

    // Response mux keyed on the last granted target; stray responses are dropped.
    always_comb begin
        rvalid_s = 1'b0;
        rdata_s  = '0;
        for (int unsigned i = 0; i < NSLAVE; i++) begin
            rvalid_s = rvalid_s | (s_resp_s[i].rvalid & (tgt_q == TgtW'(i)));
            rdata_s  = rdata_s  | (s_resp_s[i].rdata & {32{tgt_q == TgtW'(i)}});
        end
`ifdef GR_HEEP_OBI_DEMUX_ERR_RESP_EN
        rvalid_s = rvalid_s | (err_rvalid_q & (tgt_q == ERR_IDX));
        rdata_s  = rdata_s  | (ERR_RDATA & {32{tgt_q == ERR_IDX}});
`endif
        // A response with nothing in flight cannot belong to us.
        rvalid_s = rvalid_s & (cnt_q != '0);
    end

    always_comb begin
        m_resp_s.gnt    = gnt_s;
        m_resp_s.rvalid = rvalid_s;
        m_resp_s.rdata  = rdata_s;
    end

    assign master_resp_o = m_resp_s;

    // Next-state for the in-flight counter, target register and busy flag.
    always_comb begin
        case ({gnt_s, rvalid_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        if (gnt_s) begin
            tgt_d = sel_s;
        end else begin
            tgt_d = tgt_q;
        end
        busy_d = (cnt_d != '0);
    end

    // Tracking state with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tgt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tgt_q  <= tgt_d;
            busy_q <= busy_d;
        end
    end

`ifdef GR_HEEP_OBI_DEMUX_ERR_RESP_EN
    // Error target answers one cycle after each accepted request; writes are dropped.
    always_comb begin
        err_rvalid_d = gnt_s & (sel_s == ERR_IDX);
    end

    // Error-target response register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_rvalid_q <= 1'b0;
        end else begin
            err_rvalid_q <= err_rvalid_d;
        end
    end
`endif

    assign outstanding_o = cnt_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_gr_heep_obi_demux.sv
// tb_gr_heep_obi_demux: table-driven routing vectors plus hand-written
// multi-cycle sequences; response data checked through an expected-data queue.
module tb_gr_heep_obi_demux;
    import gr_heep_obi_demux_pkg::*;

    localparam int unsigned NSLAVE    = 2;
    localparam int unsigned NUM_RULES = 3;
    localparam int unsigned MAXO      = 4;
    localparam int unsigned IdxW      = 1;
    localparam int unsigned CntW      = 3;
`ifdef GR_HEEP_OBI_DEMUX_ERR_RESP_EN
    localparam int unsigned UNM = 2;
`else
    localparam int unsigned UNM = 0;
`endif

    logic                          clk_i = 1'b0;
    logic                          rst_ni;
    logic [NUM_RULES*RULE_W-1:0]   addr_map;
    logic [IdxW-1:0]               default_idx;
    obi_req_t                      m_req;
    logic [OBI_REQ_W-1:0]          master_req;
    logic [OBI_RESP_W-1:0]         master_resp;
    obi_resp_t                     m_rsp;
    logic [NSLAVE*OBI_REQ_W-1:0]   slave_req;
    obi_resp_t                     s_rsp [NSLAVE];
    logic [NSLAVE*OBI_RESP_W-1:0]  slave_resp;
    logic [CntW-1:0]               outstanding;
    logic                          busy;

    obi_req_t                      sr [NSLAVE];
    logic [31:0]                   exp_q [$];
    int                            n_tests = 0;
    int                            n_fail  = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        int unsigned tgt;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs [9];

    assign master_req = m_req;
    assign m_rsp      = obi_resp_t'(master_resp);
    assign slave_resp = {s_rsp[1], s_rsp[0]};

    gr_heep_obi_demux #(
        .NSLAVE          (NSLAVE),
        .NUM_RULES       (NUM_RULES),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .addr_map_i    (addr_map),
        .default_idx_i (default_idx),
        .master_req_i  (master_req),
        .master_resp_o (master_resp),
        .slave_req_o   (slave_req),
        .slave_resp_i  (slave_resp),
        .outstanding_o (outstanding),
        .busy_o        (busy)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Sample at the falling edge; any forwarded response is matched against the queue.
    task automatic smp();
        @(negedge clk_i);
        for (int i = 0; i < NSLAVE; i++) begin
            sr[i] = obi_req_t'(slave_req[i*OBI_REQ_W +: OBI_REQ_W]);
        end
        if (m_rsp.rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_rvalid: got rdata 0x%08h, expected no response", m_rsp.rdata);
            end else begin
                chk("sb_rdata", m_rsp.rdata, exp_q.pop_front());
            end
        end
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_m(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        m_req.req   = req;
        m_req.we    = we;
        m_req.be    = 4'hF;
        m_req.addr  = addr;
        m_req.wdata = wdata;
    endtask

    task automatic set_rv(input int i, input logic rv, input logic [31:0] rdata);
        s_rsp[i].rvalid = rv;
        s_rsp[i].rdata  = rdata;
    endtask

    initial begin
        // rule0: slave1 [0x2000_0000,0x3000_0000); rule1 overlaps, loses; rule2 index invalid
        addr_map[0*RULE_W +: RULE_W] = addr_map_rule_t'{idx: 32'd1, start_addr: 32'h2000_0000, end_addr: 32'h3000_0000};
        addr_map[1*RULE_W +: RULE_W] = addr_map_rule_t'{idx: 32'd0, start_addr: 32'h2800_0000, end_addr: 32'h4000_0000};
        addr_map[2*RULE_W +: RULE_W] = addr_map_rule_t'{idx: 32'd5, start_addr: 32'h5000_0000, end_addr: 32'h6000_0000};
        default_idx = 1'b0;

        vecs[0] = '{addr: 32'h2000_0010, we: 1'b0, tgt: 32'd1, rdata: 32'h0000_1234};
        vecs[1] = '{addr: 32'h0000_0100, we: 1'b0, tgt: 32'd0, rdata: 32'h0000_0B0B};
        vecs[2] = '{addr: 32'h2FFF_FFFC, we: 1'b1, tgt: 32'd1, rdata: 32'h0000_0000};
        vecs[3] = '{addr: 32'h3000_0000, we: 1'b0, tgt: 32'd0, rdata: 32'h3000_AAAA};
        vecs[4] = '{addr: 32'h2800_0000, we: 1'b0, tgt: 32'd1, rdata: 32'h2800_5555};
        vecs[5] = '{addr: 32'h1FFF_FFFC, we: 1'b0, tgt: UNM,   rdata: 32'h1FFF_0001};
        vecs[6] = '{addr: 32'h5000_0000, we: 1'b0, tgt: UNM,   rdata: 32'h5000_0002};
        vecs[7] = '{addr: 32'hF000_0000, we: 1'b0, tgt: UNM,   rdata: 32'hF000_0003};
        vecs[8] = '{addr: 32'h4000_0000, we: 1'b1, tgt: UNM,   rdata: 32'h4000_0004};

        set_m(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < NSLAVE; i++) begin
            s_rsp[i].gnt = 1'b1;
            set_rv(i, 1'b0, 32'h0);
        end

        // Reset state
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        smp();
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'(m_rsp.gnt), 32'd0);
        chk("rst_slave_req", {30'd0, sr[1].req, sr[0].req}, 32'd0);
        adv();
        rst_ni = 1'b1;
        adv();

        // Routing vectors: issue, one response, drain
        for (int v = 0; v < 9; v++) begin
            set_m(1'b1, vecs[v].we, vecs[v].addr, 32'hC0DE_0000 | 32'(v));
            smp();
            chk($sformatf("v%0d_req0", v), 32'(sr[0].req), 32'(vecs[v].tgt == 32'd0));
            chk($sformatf("v%0d_req1", v), 32'(sr[1].req), 32'(vecs[v].tgt == 32'd1));
            chk($sformatf("v%0d_gnt", v), 32'(m_rsp.gnt), 32'd1);
            chk($sformatf("v%0d_bcast_addr", v), sr[0].addr, vecs[v].addr);
            chk($sformatf("v%0d_bcast_wdata", v), sr[1].wdata, 32'hC0DE_0000 | 32'(v));
            adv();
            set_m(1'b0, 1'b0, 32'h0, 32'h0);
            if (vecs[v].tgt < NSLAVE) begin
                set_rv(int'(vecs[v].tgt), 1'b1, vecs[v].rdata);
                exp_q.push_back(vecs[v].rdata);
            end else begin
                exp_q.push_back(ERR_RDATA);
            end
            smp();
            chk($sformatf("v%0d_rvalid", v), 32'(m_rsp.rvalid), 32'd1);
            chk($sformatf("v%0d_outst1", v), 32'(outstanding), 32'd1);
            chk($sformatf("v%0d_busy1", v), 32'(busy), 32'd1);
            adv();
            set_rv(0, 1'b0, 32'h0);
            set_rv(1, 1'b0, 32'h0);
            smp();
            chk($sformatf("v%0d_outst0", v), 32'(outstanding), 32'd0);
            chk($sformatf("v%0d_busy0", v), 32'(busy), 32'd0);
            adv();
        end

        // Window limit: four writes granted, fifth held off until a response retires
        for (int k = 0; k < 4; k++) begin
            set_m(1'b1, 1'b1, 32'h2000_0100 + 32'(4 * k), 32'(k));
            smp();
            chk($sformatf("win_gnt%0d", k), 32'(m_rsp.gnt), 32'd1);
            chk($sformatf("win_outst%0d", k), 32'(outstanding), 32'(k));
            adv();
        end
        set_m(1'b1, 1'b1, 32'h2000_0110, 32'd4);
        smp();
        chk("win_full_gnt", 32'(m_rsp.gnt), 32'd0);
        chk("win_full_req1", 32'(sr[1].req), 32'd0);
        chk("win_full_outst", 32'(outstanding), 32'd4);
        adv();
        set_rv(1, 1'b1, 32'h0000_00A0);
        exp_q.push_back(32'h0000_00A0);
        smp();
        chk("win_rv_gnt", 32'(m_rsp.gnt), 32'd0);
        adv();
        set_rv(1, 1'b0, 32'h0);
        smp();
        chk("win_after_gnt", 32'(m_rsp.gnt), 32'd1);
        chk("win_after_outst", 32'(outstanding), 32'd3);
        adv();
        set_m(1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            set_rv(1, 1'b1, 32'h0000_00B0 + 32'(k));
            exp_q.push_back(32'h0000_00B0 + 32'(k));
            smp();
            chk($sformatf("win_drain%0d", k), 32'(outstanding), 32'(4 - k));
            adv();
        end
        set_rv(1, 1'b0, 32'h0);
        smp();
        chk("win_empty", 32'(outstanding), 32'd0);
        adv();

        // Target switch stalls until the previous target has answered
        set_m(1'b1, 1'b0, 32'h2000_0020, 32'h0);
        smp();
        chk("sw_first_gnt", 32'(m_rsp.gnt), 32'd1);
        adv();
        set_m(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        set_rv(0, 1'b1, 32'h5555_5555);
        smp();
        chk("sw_stall_gnt", 32'(m_rsp.gnt), 32'd0);
        chk("sw_stall_req", {30'd0, sr[1].req, sr[0].req}, 32'd0);
        chk("sw_stray_rvalid", 32'(m_rsp.rvalid), 32'd0);
        adv();
        set_rv(0, 1'b0, 32'h0);
        set_rv(1, 1'b1, 32'h0000_2222);
        exp_q.push_back(32'h0000_2222);
        smp();
        chk("sw_rv_outst", 32'(outstanding), 32'd1);
        adv();
        set_rv(1, 1'b0, 32'h0);
        smp();
        chk("sw_gnt", 32'(m_rsp.gnt), 32'd1);
        chk("sw_req0", 32'(sr[0].req), 32'd1);
        chk("sw_outst", 32'(outstanding), 32'd0);
        adv();
        set_m(1'b0, 1'b0, 32'h0, 32'h0);
        set_rv(0, 1'b1, 32'h0000_3333);
        exp_q.push_back(32'h0000_3333);
        smp();
        adv();
        set_rv(0, 1'b0, 32'h0);
        smp();
        chk("sw_done", 32'(outstanding), 32'd0);
        adv();

        // Grant and response in the same cycle leave the count unchanged
        set_m(1'b1, 1'b0, 32'h2000_0030, 32'h0);
        smp();
        adv();
        smp();
        adv();
        set_rv(1, 1'b1, 32'h0000_4444);
        exp_q.push_back(32'h0000_4444);
        smp();
        chk("same_gnt", 32'(m_rsp.gnt), 32'd1);
        chk("same_outst_pre", 32'(outstanding), 32'd2);
        adv();
        set_m(1'b0, 1'b0, 32'h0, 32'h0);
        set_rv(1, 1'b0, 32'h0);
        smp();
        chk("same_outst", 32'(outstanding), 32'd2);
        chk("same_busy", 32'(busy), 32'd1);
        adv();
        for (int k = 0; k < 2; k++) begin
            set_rv(1, 1'b1, 32'h0000_4450 + 32'(k));
            exp_q.push_back(32'h0000_4450 + 32'(k));
            smp();
            adv();
        end
        set_rv(1, 1'b0, 32'h0);
        smp();
        chk("same_done", 32'(outstanding), 32'd0);
        adv();

        // Asynchronous reset with three in flight; a late response is ignored
        set_m(1'b1, 1'b0, 32'h2000_0040, 32'h0);
        for (int k = 0; k < 3; k++) begin
            smp();
            adv();
        end
        set_m(1'b0, 1'b0, 32'h0, 32'h0);
        smp();
        chk("arst_pre_outst", 32'(outstanding), 32'd3);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_outst", 32'(outstanding), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        adv();
        rst_ni = 1'b1;
        set_rv(1, 1'b1, 32'hDEAD_0001);
        smp();
        chk("arst_late_rvalid", 32'(m_rsp.rvalid), 32'd0);
        adv();
        set_rv(1, 1'b0, 32'h0);
        smp();
        chk("arst_late_outst", 32'(outstanding), 32'd0);
        adv();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
